add_pipe_cla: RTL and testbench
===============================

ADD_PIPE_CLA -- requirements
Module: add_pipe_cla

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand and sum width in bits.
REQ-002 The block SHALL have parameter STAGES, default 2, meaning the number of pipeline register stages (1..8).
REQ-003 The block SHALL have parameter GROUP, default 4, meaning the carry-lookahead group width in bits.
REQ-004 Port clk SHALL be input, 1 bit: the single clock, with all state on its rising edge.
REQ-005 Port rst_n SHALL be input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port in_valid SHALL be input, 1 bit: the operand set is presented.
REQ-007 Port in_ready SHALL be output, 1 bit: the block accepts operands this cycle.
REQ-008 Ports a and b SHALL be inputs, WIDTH bits each: the operands.
REQ-009 Port cin SHALL be input, 1 bit: carry-in, used only when sub=0.
REQ-010 Port sub SHALL be input, 1 bit: 1 selects a-b, 0 selects a+b+cin.
REQ-011 Port out_valid SHALL be output, 1 bit: the result is presented.
REQ-012 Port out_ready SHALL be input, 1 bit: the consumer accepts the result.
REQ-013 Port sum SHALL be output, WIDTH bits: the result modulo 2^WIDTH.
REQ-014 Port cout SHALL be output, 1 bit: the carry-out of the MSB (for subtraction, 1 means no borrow).
REQ-015 Port ovf SHALL be output, 1 bit: two's-complement signed overflow.

Function
REQ-016 A transfer SHALL occur on a clock edge where valid and ready are both 1, on either side.
REQ-017 When sub=1, the effective operation SHALL be a + ~b + 1, and cin SHALL be ignored.
REQ-018 Operands SHALL be split into STAGES slices of WIDTH/STAGES bits; stage k adds slice k using lookahead over GROUP-bit groups and the carry registered from stage k-1.
REQ-019 Not-yet-added upper operand slices and completed lower sum slices SHALL be carried forward in pipeline registers alongside each item.
REQ-020 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with an unstalled consumer.
REQ-021 Throughput SHALL be one result per cycle when out_ready=1.
REQ-022 Each stage SHALL hold a valid bit and advance when the next stage is empty or advancing, so in_ready SHALL be 1 whenever stage 0 is empty or advancing.
REQ-023 in_ready SHALL depend combinationally on out_ready; no skid buffer is included.
REQ-024 The pipeline SHALL hold at most STAGES items; with out_ready=0 and the pipeline full, in_ready SHALL be 0 and all held data SHALL be stable.
REQ-025 Results SHALL emerge in acceptance order, with none lost or duplicated.
REQ-026 ovf SHALL be the XOR of the carry into the MSB and the carry out of the MSB.
REQ-027 Simultaneous input acceptance and output transfer on a full pipeline SHALL be legal and lossless.
REQ-028 Wrap-around SHALL be silent: sum is modulo 2^WIDTH, and cout/ovf report it.

Reset
REQ-029 While rst_n=0, all stage valid bits, out_valid, sum, cout and ovf SHALL be 0.
REQ-030 While rst_n=0, in_ready SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight items; none SHALL appear after reset release.
REQ-032 in_ready SHALL be 1 from the first edge after rst_n rises.

Structure
REQ-033 A shared package add_pkg SHALL hold the default WIDTH/STAGES/GROUP constants and a per-item stage-record typedef (valid, carry, partial sum, remaining operand slices).
REQ-034 One combinational sub-module cla_group SHALL compute a GROUP-bit sum plus group propagate/generate; each stage SHALL instantiate WIDTH/(STAGES*GROUP) of them with a group-level lookahead.
REQ-035 Elaboration SHALL fail unless WIDTH divides by STAGES*GROUP.

Verification (WIDTH=16, STAGES=2, GROUP=4)
REQ-036 0xFFFF+0x0001, cin=0, sub=0 -> after 2 cycles sum=0x0000, cout=1, ovf=0.
REQ-037 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; 0x8000+0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-038 sub=1, 0x0005-0x0007, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored).
REQ-039 Back-to-back inputs 1+1, 2+2, 3+3, 4+4 with out_ready=0 for 4 cycles -> in_ready falls after 2 accepts; the outputs 2, 4, 6, 8 appear in order with none lost.
REQ-040 Reset pulse with 2 items in flight -> out_valid=0 immediately; no results after release; in_ready=1 on the next edge.
REQ-041 A random constrained stream of 10k operations with random out_ready SHALL match a reference model {cout,sum}=a+b+cin (or a+~b+1).

Source files
------------

// File: rtl/add_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
// Holds default geometry, the per-item stage record and the carry merge helper.
package add_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 2;
  localparam int DEF_GROUP  = 4;

  // One in-flight item at the default geometry: lower sum slices accumulate in acc
  // from the top down, while ra/rb shift right as their low slice is consumed.
  typedef struct packed {
    logic                 vld;
    logic                 carry;
    logic                 ovf;
    logic [DEF_WIDTH-1:0] acc;
    logic [DEF_WIDTH-1:0] ra;
    logic [DEF_WIDTH-1:0] rb;
  } stage_rec_t;

  function automatic logic lookahead(input logic g, input logic p, input logic c);
    return g | (p & c);
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead cell: sum for a given carry-in plus
// group propagate/generate, which do not depend on the carry-in.
module cla_group
  import add_pkg::*;
#(
  parameter int GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             p,
  output logic             g
);

  logic [GROUP-1:0] bp;
  logic [GROUP-1:0] bg;
  logic [GROUP-1:0] c;

  always_comb begin
    bp   = a ^ b;
    bg   = a & b;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < GROUP - 1; i++) begin
      c[i+1] = lookahead(bg[i], bp[i], c[i]);
    end
    s = bp ^ c;
    p = &bp;
    g = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      g = lookahead(bg[i], bp[i], g);
    end
  end

endmodule

// File: rtl/add_pipe_cla.sv
// Pipelined adder/subtractor: STAGES slices, each a group-lookahead add over cla_group cells.
// Latency STAGES cycles; each stage advances when the next is empty or advancing (no skid).
module add_pipe_cla
  import add_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int GROUP  = DEF_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int NG    = SLICE / GROUP;

  if ((STAGES < 1) || (STAGES > 8)) begin : g_bad_stages
    $error("add_pipe_cla: STAGES must be in 1..8");
  end
  if ((WIDTH % (STAGES * GROUP)) != 0) begin : g_bad_width
    $error("add_pipe_cla: WIDTH must be divisible by STAGES*GROUP");
  end

  typedef struct packed {
    logic             vld;
    logic             carry;
    logic             ovf;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
  } stage_t;

  stage_t            in_rec;
  stage_t            nxt  [STAGES];
  stage_t            st_d [STAGES];
  stage_t            st_q [STAGES];
  logic [STAGES:0]   adv;

  // Subtraction folds into the adder as a + ~b + 1.
  always_comb begin
    in_rec       = '0;
    in_rec.vld   = in_valid;
    in_rec.carry = sub ? 1'b1 : cin;
    in_rec.ra    = a;
    in_rec.rb    = sub ? ~b : b;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           src;
    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic [SLICE-1:0] ss;
    logic [NG:0]      gc;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic [WIDTH-1:0] acc_n;
    logic             c_msb;

    if (k == 0) begin : g_src_in
      assign src = in_rec;
    end else begin : g_src_reg
      assign src = st_q[k-1];
    end

    assign sa = src.ra[SLICE-1:0];
    assign sb = src.rb[SLICE-1:0];

    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
        .a  (sa[j*GROUP +: GROUP]),
        .b  (sb[j*GROUP +: GROUP]),
        .ci (gc[j]),
        .s  (ss[j*GROUP +: GROUP]),
        .p  (gp[j]),
        .g  (gg[j])
      );
    end

    always_comb begin
      gc    = '0;
      gc[0] = src.carry;
      for (int j = 0; j < NG; j++) begin
        gc[j+1] = lookahead(gg[j], gp[j], gc[j]);
      end
    end

    // Carry into the slice MSB recovered from its sum bit; only the last stage's value survives.
    assign c_msb = ss[SLICE-1] ^ sa[SLICE-1] ^ sb[SLICE-1];

    if (SLICE == WIDTH) begin : g_acc_full
      assign acc_n = ss;
    end else begin : g_acc_shift
      assign acc_n = {ss, src.acc[WIDTH-1:SLICE]};
    end

    assign nxt[k] = '{vld:   src.vld,
                      carry: gc[NG],
                      ovf:   c_msb ^ gc[NG],
                      acc:   acc_n,
                      ra:    src.ra >> SLICE,
                      rb:    src.rb >> SLICE};
  end

  always_comb begin
    adv         = '0;
    adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = !st_q[k].vld || adv[k+1];
    end
    for (int k = 0; k < STAGES; k++) begin
      st_d[k] = adv[k] ? nxt[k] : st_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  assign in_ready  = rst_n & adv[0];
  assign out_valid = st_q[STAGES-1].vld;
  assign sum       = st_q[STAGES-1].acc;
  assign cout      = st_q[STAGES-1].carry;
  assign ovf       = st_q[STAGES-1].ovf;

endmodule

// File: tb/tb_add_pipe_cla.sv
// Directed vector table, backpressure/reset sequences and a scoreboarded random stream
// for add_pipe_cla at WIDTH=16, STAGES=2, GROUP=4.
module tb_add_pipe_cla;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  add_pipe_cla #(.WIDTH(16), .STAGES(2), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    string        name;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum}; signed overflow from operand/result signs.
  function automatic logic [17:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c, input logic s);
    logic [W-1:0] yy;
    logic [W:0]   r;
    logic         o;
    yy = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + {16'd0, (s ? 1'b1 : c)};
    o  = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
    return {o, r[W], r[W-1:0]};
  endfunction

  task automatic run_vec(input vec_t v);
    int t;
    int lat;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk); #1; t++;
    end
    check({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check({v.name, "_latency"}, 32'(lat), 32'd2);
    check({v.name, "_sum"},  32'(sum),  32'(v.es));
    check({v.name, "_cout"}, 32'(cout), 32'(v.ec));
    check({v.name, "_ovf"},  32'(ovf),  32'(v.eo));
  endtask

  initial begin
    vec_t       vt [11];
    logic       rdy_seen [4];
    logic [W-1:0] outs [4];
    int         idx;
    int         got;
    int         t;
    logic       acc;
    logic       seen;
    logic [17:0] expq [$];
    int         sent;
    int         cyc;
    logic       last_acc;

    vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "ffff_plus_1"};
    vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "7fff_plus_1"};
    vt[2]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "8000_plus_8000"};
    vt[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "5_minus_7"};
    vt[4]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, "plain_cin"};
    vt[5]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "8000_minus_1"};
    vt[6]  = '{16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "7_minus_7"};
    vt[7]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "group_carry"};
    vt[8]  = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, "stage_carry"};
    vt[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "all_ones_cin"};
    vt[10] = '{16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, "0_minus_8000"};

    // Reset state, with a valid offered during reset.
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      run_vec(vt[i]);
    end

    // Backpressure: four items offered against a stalled consumer.
    @(negedge clk);
    out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      a = 16'(idx + 1); b = 16'(idx + 1); in_valid = 1'b1;
      #1;
      rdy_seen[c] = in_ready;
      @(posedge clk);
      if (rdy_seen[c]) idx++;
    end
    check("bp_rdy0", 32'(rdy_seen[0]), 32'd1);
    check("bp_rdy1", 32'(rdy_seen[1]), 32'd1);
    check("bp_rdy2", 32'(rdy_seen[2]), 32'd0);
    check("bp_rdy3", 32'(rdy_seen[3]), 32'd0);
    check("bp_accepts", 32'(idx), 32'd2);
    @(negedge clk);
    #1;
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_sum",   32'(sum),       32'd2);
    check("bp_full_rdy",   32'(in_ready),  32'd0);
    got = 0;
    t = 0;
    while (got < 4 && t < 30) begin
      if (t > 0) @(negedge clk);
      out_ready = 1'b1;
      if (idx < 4) begin
        a = 16'(idx + 1); b = 16'(idx + 1); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        outs[got] = sum;
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
      t++;
    end
    check("bp_count", 32'(got), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got) check($sformatf("bp_out%0d", i), 32'(outs[i]), 32'(2 * (i + 1)));
    end
    @(negedge clk);
    in_valid = 1'b0;

    // Reset with two items in flight.
    out_ready = 1'b0;
    a = 16'h0005; b = 16'h0005; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'h0006; b = 16'h0006;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 0) check("mid_post_ready", 32'(in_ready), 32'd1);
      seen = seen | out_valid;
    end
    check("mid_no_ghost", 32'(seen), 32'd0);

    // Random stream against the reference model.
    sent = 0; got = 0; cyc = 0; last_acc = 1'b0;
    while (got < 10000 && cyc < 60000) begin
      @(negedge clk);
      if (last_acc) in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < 10000 && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 5))
          0:       a = 16'hFFFF;
          1:       a = 16'h8000;
          default: a = 16'($urandom);
        endcase
        case ($urandom_range(0, 5))
          0:       b = 16'h7FFF;
          1:       b = 16'h0001;
          default: b = 16'($urandom);
        endcase
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("rand_unexpected", 32'(sum), 32'hDEAD_0000);
        end else begin
          check($sformatf("rand_%0d", got), 32'({ovf, cout, sum}), 32'(expq.pop_front()));
        end
        got++;
      end
      last_acc = in_valid && in_ready;
      if (last_acc) begin
        expq.push_back(model(a, b, cin, sub));
        sent++;
      end
      @(posedge clk);
      cyc++;
    end
    check("rand_results", 32'(got), 32'd10000);
    check("rand_drained", 32'(expq.size()), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
